data_sram_responder: RTL

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder with fixed-latency in-order response queue
//
// Ports:
//   clk               : single clock, rising edge
//   resetn            : asynchronous active-low reset
//   data_sram_req     : request valid
//   data_sram_wr      : 1 = write, 0 = read
//   data_sram_size    : access size (not used by the storage)
//   data_sram_wstrb   : byte write enables
//   data_sram_addr    : byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata   : lane-replicated write data
//   data_sram_addr_ok : request accepted this cycle (combinational)
//   data_sram_data_ok : response for the oldest outstanding request
//   data_sram_rdata   : read data, zero unless data_ok for a read
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [2:0]    CD_INIT  = 3'(LATENCY - 1);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic              q_valid [DEPTH];
  logic              q_wr    [DEPTH];
  logic [31:0]       q_data  [DEPTH];
  logic [2:0]        q_cd    [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic              accept;
  logic              retire;
  logic              unused_bits;

  assign word_idx = data_sram_addr[ADDR_W+1:2];
  assign rd_word  = mem[word_idx];
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A full queue can still accept when its head retires on the same edge,
  // because the retiring slot is the one the tail points at.
  assign retire            = q_valid[head] && (q_cd[head] == 3'd0);
  assign data_sram_data_ok = retire;
  assign data_sram_addr_ok = (count < DEPTH_C) || retire;
  assign accept            = data_sram_req && data_sram_addr_ok;
  assign data_sram_rdata   = (retire && !q_wr[head]) ? q_data[head] : 32'b0;

  // Storage is never reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (resetn && accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_wr[i]    <= 1'b0;
        q_data[i]  <= 32'b0;
        q_cd[i]    <= 3'd0;
      end
    end else begin
      // Entries behind the head that reach zero simply wait there.
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && (q_cd[i] != 3'd0)) begin
          q_cd[i] <= q_cd[i] - 3'd1;
        end
      end

      if (retire) begin
        q_valid[head] <= 1'b0;
        head          <= ptr_inc(head);
      end

      // Later assignment wins when a full queue recycles the retiring slot.
      // Reads snapshot the word now, so earlier writes are already visible.
      if (accept) begin
        q_valid[tail] <= 1'b1;
        q_wr[tail]    <= data_sram_wr;
        q_data[tail]  <= data_sram_wr ? 32'b0 : rd_word;
        q_cd[tail]    <= CD_INIT;
        tail          <= ptr_inc(tail);
      end

      if (accept && !retire) begin
        count <= count + CW'(1);
      end else if (retire && !accept) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
